// File: rtl/tblink_rpc_cmdproc_pkg.sv
// Shared types and constants for the tblink RPC command processor.
package tblink_rpc_cmdproc_pkg;

    typedef enum logic [1:0] {
        RX_CMD   = 2'd0,
        RX_SZ    = 2'd1,
        RX_PARAM = 2'd2
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_CMD  = 2'd1,
        TX_SZ   = 2'd2,
        TX_RSP  = 2'd3
    } tx_state_e;

    // Byte offsets of the packet header within a slot's header store.
    localparam bit HDR_CMD = 1'b0;
    localparam bit HDR_SZ  = 1'b1;

    // Limit a requested byte count to what the response register can hold.
    function automatic logic [7:0] clamp_sz(input logic [7:0] sz, input logic [7:0] max_sz);
        return (sz > max_sz) ? max_sz : sz;
    endfunction

endpackage

// File: rtl/tblink_rpc_cmdproc_q_if.sv
// Byte-stream handshake bundle: tipo carries packets in, tipi carries responses out.
interface tblink_rpc_cmdproc_q_if;

    logic [7:0] tipo_dat;
    logic       tipo_valid;
    logic       tipo_ready;
    logic [7:0] tipi_dat;
    logic       tipi_valid;
    logic       tipi_ready;

    // Host side: produces commands, consumes responses.
    modport master (
        output tipo_dat,
        output tipo_valid,
        input  tipo_ready,
        input  tipi_dat,
        input  tipi_valid,
        output tipi_ready
    );

    // Command processor side.
    modport slave (
        input  tipo_dat,
        input  tipo_valid,
        output tipo_ready,
        output tipi_dat,
        output tipi_valid,
        input  tipi_ready
    );

endinterface

// File: rtl/tblink_rpc_cmdproc_rsp_tx.sv
// Response serializer: captures a retired command's response and streams
// {cmd, n, rsp bytes LSB first} out on the tipi handshake.
module tblink_rpc_cmdproc_rsp_tx
    import tblink_rpc_cmdproc_pkg::*;
#(
    parameter int unsigned CMD_IN_RSP_SZ = 1
) (
    input  logic                       uclock,
    input  logic                       reset,
    input  logic                       retire,
    input  logic [7:0]                 ret_cmd,
    input  logic [CMD_IN_RSP_SZ*8-1:0] cmd_in_rsp,
    input  logic [7:0]                 cmd_in_rsp_sz,
    output logic                       cmd_in_rsp_rdy,
    output logic [7:0]                 tipi_dat,
    output logic                       tipi_valid,
    input  logic                       tipi_ready
);

    tx_state_e                  tx_state;
    logic [CMD_IN_RSP_SZ*8-1:0] cap_rsp;
    logic [7:0]                 cap_n;
    logic [7:0]                 rem;
    logic                       tx_xfer;

    assign tx_xfer = tipi_valid && tipi_ready;

    // TX FSM: capture on retire, then advance one byte per accepted transfer.
    always_ff @(posedge uclock) begin
        if (!reset) begin
            tx_state       <= TX_IDLE;
            cap_rsp        <= '0;
            cap_n          <= '0;
            rem            <= '0;
            tipi_dat       <= '0;
            tipi_valid     <= 1'b0;
            cmd_in_rsp_rdy <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (retire) begin
                        cap_rsp        <= cmd_in_rsp;
                        cap_n          <= clamp_sz(cmd_in_rsp_sz, 8'(CMD_IN_RSP_SZ));
                        cmd_in_rsp_rdy <= 1'b0;
                        tipi_valid     <= 1'b1;
                        tipi_dat       <= ret_cmd;
                        tx_state       <= TX_CMD;
                    end
                end
                TX_CMD: begin
                    if (tx_xfer) begin
                        tipi_dat <= cap_n;
                        tx_state <= TX_SZ;
                    end
                end
                TX_SZ: begin
                    if (tx_xfer) begin
                        if (cap_n == 8'd0) begin
                            tipi_valid     <= 1'b0;
                            tipi_dat       <= '0;
                            cmd_in_rsp_rdy <= 1'b1;
                            tx_state       <= TX_IDLE;
                        end else begin
                            tipi_dat <= cap_rsp[7:0];
                            cap_rsp  <= cap_rsp >> 8;
                            rem      <= cap_n - 8'd1;
                            tx_state <= TX_RSP;
                        end
                    end
                end
                TX_RSP: begin
                    if (tx_xfer) begin
                        if (rem == 8'd0) begin
                            tipi_valid     <= 1'b0;
                            tipi_dat       <= '0;
                            cmd_in_rsp_rdy <= 1'b1;
                            tx_state       <= TX_IDLE;
                        end else begin
                            tipi_dat <= cap_rsp[7:0];
                            cap_rsp  <= cap_rsp >> 8;
                            rem      <= rem - 8'd1;
                        end
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/tblink_rpc_cmdproc_q.sv
// Command processor queue: parses inbound {cmd, sz, params} packets into a
// ring of flop slots, exposes the head slot to the consumer and returns the
// consumer's responses through the serializer sub-module.
module tblink_rpc_cmdproc_q
    import tblink_rpc_cmdproc_pkg::*;
#(
    parameter int unsigned  CMD_IN_PARAMS_SZ = 4,
    parameter int unsigned  CMD_IN_RSP_SZ    = 1,
    parameter int unsigned  DEPTH            = 4,
    localparam int unsigned PTR_W            = $clog2(DEPTH) + 1
) (
    input  logic                          uclock,
    input  logic                          reset,
    tblink_rpc_cmdproc_q_if.slave         tp,
    output logic [7:0]                    cmd_in,
    output logic [7:0]                    cmd_in_sz,
    output logic [CMD_IN_PARAMS_SZ*8-1:0] cmd_in_params,
    output logic [PTR_W-1:0]              cmd_in_put_i,
    input  logic [PTR_W-1:0]              cmd_in_get_i,
    input  logic [CMD_IN_RSP_SZ*8-1:0]    cmd_in_rsp,
    input  logic [7:0]                    cmd_in_rsp_sz,
    output logic                          cmd_in_rsp_rdy,
    output logic [7:0]                    err_cnt
);

    localparam int unsigned IDX_W = PTR_W - 1;

    rx_state_e                     rx_state;
    logic [PTR_W-1:0]              put_i;
    logic [PTR_W-1:0]              get_q;
    logic [7:0]                    rx_sz;
    logic [7:0]                    rx_k;
    logic [7:0]                    err_q;
    logic [7:0]                    slot_hdr    [DEPTH][2];
    logic [CMD_IN_PARAMS_SZ*8-1:0] slot_params [DEPTH];
    logic [IDX_W-1:0]              put_idx;
    logic [IDX_W-1:0]              get_idx;
    logic [IDX_W-1:0]              ret_idx;
    logic                          full;
    logic                          rx_xfer;
    logic                          retire;

    assign put_idx = put_i[IDX_W-1:0];
    assign get_idx = cmd_in_get_i[IDX_W-1:0];
    assign ret_idx = get_q[IDX_W-1:0];

    assign full          = (put_i ^ cmd_in_get_i) == {1'b1, {(PTR_W-1){1'b0}}};
    assign tp.tipo_ready = !((rx_state == RX_CMD) && full);
    assign rx_xfer       = tp.tipo_valid && tp.tipo_ready;

    // A retire is any change of the consumer pointer since the previous edge.
    assign retire = (cmd_in_get_i != get_q);

    assign cmd_in        = slot_hdr[get_idx][HDR_CMD];
    assign cmd_in_sz     = slot_hdr[get_idx][HDR_SZ];
    assign cmd_in_params = slot_params[get_idx];
    assign cmd_in_put_i  = put_i;
    assign err_cnt       = err_q;

    // Track the consumer pointer so a retire can be detected and the retired slot located.
    always_ff @(posedge uclock) begin
        if (!reset) begin
            get_q <= '0;
        end else begin
            get_q <= cmd_in_get_i;
        end
    end

    // RX FSM: header/param parsing into slot put_i, commit advances put_i.
    always_ff @(posedge uclock) begin
        if (!reset) begin
            rx_state <= RX_CMD;
            put_i    <= '0;
            rx_sz    <= '0;
            rx_k     <= '0;
            err_q    <= '0;
            for (int unsigned s = 0; s < DEPTH; s++) begin
                slot_hdr[s][HDR_CMD] <= '0;
                slot_hdr[s][HDR_SZ]  <= '0;
                slot_params[s]       <= '0;
            end
        end else if (rx_xfer) begin
            case (rx_state)
                RX_CMD: begin
                    // Parameters are cleared up front so unreceived bytes read zero.
                    slot_hdr[put_idx][HDR_CMD] <= tp.tipo_dat;
                    slot_params[put_idx]       <= '0;
                    rx_state                   <= RX_SZ;
                end
                RX_SZ: begin
                    slot_hdr[put_idx][HDR_SZ] <= tp.tipo_dat;
                    rx_sz                     <= tp.tipo_dat;
                    rx_k                      <= '0;
                    if (tp.tipo_dat == 8'd0) begin
                        put_i    <= put_i + PTR_W'(1);
                        rx_state <= RX_CMD;
                    end else begin
                        rx_state <= RX_PARAM;
                    end
                end
                RX_PARAM: begin
                    for (int unsigned b = 0; b < CMD_IN_PARAMS_SZ; b++) begin
                        if (rx_k == 8'(b)) begin
                            slot_params[put_idx][8*b +: 8] <= tp.tipo_dat;
                        end
                    end
                    rx_k <= rx_k + 8'd1;
                    if (rx_k == rx_sz - 8'd1) begin
                        put_i    <= put_i + PTR_W'(1);
                        rx_state <= RX_CMD;
                        if ((rx_sz > 8'(CMD_IN_PARAMS_SZ)) && (err_q != 8'hFF)) begin
                            err_q <= err_q + 8'd1;
                        end
                    end
                end
                default: rx_state <= RX_CMD;
            endcase
        end
    end

    tblink_rpc_cmdproc_rsp_tx #(
        .CMD_IN_RSP_SZ(CMD_IN_RSP_SZ)
    ) u_rsp_tx (
        .uclock         (uclock),
        .reset          (reset),
        .retire         (retire),
        .ret_cmd        (slot_hdr[ret_idx][HDR_CMD]),
        .cmd_in_rsp     (cmd_in_rsp),
        .cmd_in_rsp_sz  (cmd_in_rsp_sz),
        .cmd_in_rsp_rdy (cmd_in_rsp_rdy),
        .tipi_dat       (tp.tipi_dat),
        .tipi_valid     (tp.tipi_valid),
        .tipi_ready     (tp.tipi_ready)
    );

endmodule

// File: doc/tblink_rpc_cmdproc_q.md
TBLINK_RPC_CMDPROC_Q -- requirements
Module: tblink_rpc_cmdproc_q

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  - CMD_IN_PARAMS_SZ, 4, max parameter bytes stored per command.
  - CMD_IN_RSP_SZ, 1, max response bytes returned per command.
  - DEPTH, 4, command slots; power of two, >= 2.
  - PTR_W, $clog2(DEPTH)+1, derived, not overridable.
REQ-002 Ports, one per line: name, direction, width, meaning.
  - uclock, in, 1, sole clock.
  - reset, in, 1, synchronous, active-low.
  - tipo_dat, in, 8, inbound packet byte.
  - tipo_valid, in, 1, inbound byte valid.
  - tipo_ready, out, 1, inbound byte accepted.
  - tipi_dat, out, 8, outbound response byte.
  - tipi_valid, out, 1, outbound byte valid.
  - tipi_ready, in, 1, outbound byte accepted.
  - cmd_in, out, 8, head-slot command code.
  - cmd_in_sz, out, 8, head-slot parameter count as received, unclamped.
  - cmd_in_params, out, CMD_IN_PARAMS_SZ*8, head-slot parameters.
  - cmd_in_put_i, out, PTR_W, producer pointer.
  - cmd_in_get_i, in, PTR_W, consumer pointer.
  - cmd_in_rsp, in, CMD_IN_RSP_SZ*8, response data.
  - cmd_in_rsp_sz, in, 8, response byte count.
  - cmd_in_rsp_rdy, out, 1, response capture register free.
  - err_cnt, out, 8, saturating count of oversize packets.

Function
REQ-003 A byte transfers when valid and ready are both high on a rising uclock edge.
REQ-004 The inbound packet format SHALL be: byte0 cmd, byte1 sz, then sz parameter bytes.
REQ-005 The RX FSM SHALL use states RX_CMD -> RX_SZ -> RX_PARAM -> RX_CMD; RX_SZ with sz==0 returns directly to RX_CMD.
REQ-006 Parameter byte k SHALL land in cmd_in_params[8k+7:8k]; unreceived bytes of the slot SHALL read zero.
REQ-007 Bytes with k >= CMD_IN_PARAMS_SZ SHALL be accepted and discarded, and err_cnt SHALL increment once per such packet, saturating at 255.
REQ-008 Full = (put_i ^ get_i) == {1'b1, {PTR_W-1{1'b0}}}; empty = put_i == get_i.
REQ-009 tipo_ready SHALL be low in RX_CMD while full, and high in every other RX state.
REQ-010 cmd_in_put_i SHALL increment, with natural wrap at 2^PTR_W, on the cycle after the last byte of a packet is accepted.
REQ-011 cmd_in, cmd_in_sz and cmd_in_params SHALL show slot get_i[PTR_W-2:0]; they are valid only while not empty.
REQ-012 The consumer retires a command by incrementing cmd_in_get_i by 1, presenting cmd_in_rsp and cmd_in_rsp_sz on that same cycle.
REQ-013 The DUT SHALL capture the response on the cycle get_i changes, and cmd_in_rsp_rdy SHALL drop on the next cycle.
REQ-014 The consumer SHALL NOT advance get_i while cmd_in_rsp_rdy is low; such an advance is undefined behaviour.
REQ-015 The TX FSM SHALL use states TX_IDLE -> TX_CMD -> TX_SZ -> TX_RSP -> TX_IDLE.
REQ-016 The outbound packet SHALL be: byte0 = retired slot cmd, byte1 = min(cmd_in_rsp_sz, CMD_IN_RSP_SZ) = n, then n bytes of cmd_in_rsp, LSB byte first.
REQ-017 TX_SZ with n==0 SHALL go directly to TX_IDLE.
REQ-018 tipi_valid SHALL rise on the cycle after capture; tipi_dat SHALL hold stable while tipi_valid is high and tipi_ready is low.
REQ-019 cmd_in_rsp_rdy SHALL return high on the cycle after the last outbound byte is accepted.
REQ-020 A commit and a retire in the same cycle SHALL both take effect; the occupancy is then unchanged.
REQ-021 A packet in progress SHALL use the slot at put_i; full is evaluated only in RX_CMD.

Reset
REQ-022 On reset low at a uclock edge, the block SHALL return to the following state:
  - RX FSM = RX_CMD, TX FSM = TX_IDLE.
  - put_i = 0, err_cnt = 0.
  - tipo_ready = 1, tipi_valid = 0, tipi_dat = 0, cmd_in_rsp_rdy = 1.
  - Slot contents = 0.
REQ-023 A reset asserted mid-packet SHALL discard the partial inbound packet and abort any outbound packet; no truncated byte is emitted after reset.
REQ-024 The consumer SHALL reset get_i to 0 under the same reset.

Structure
REQ-025 Package tblink_rpc_cmdproc_pkg SHALL hold the rx_state_e and tx_state_e enums and the header-offset constants (HDR_CMD=0, HDR_SZ=1).
REQ-026 The response serializer SHALL be sub-module tblink_rpc_cmdproc_rsp_tx, covering the TX FSM and capture register.
REQ-027 Slot storage SHALL be flops; no RAM macro is used.

Verification
REQ-028 Send {0x11, 0x02, 0xAA, 0xBB} -> put_i goes 0->1 one cycle after 0xBB is accepted; cmd_in=0x11, cmd_in_sz=2, cmd_in_params=0x0000BBAA.
REQ-029 Fill 4 slots, then offer a 5th packet -> tipo_ready stays low; after one retire, tipo_ready rises and the 5th packet commits into slot 0 with put_i=5.
REQ-030 Send cmd 0x22, sz=6 with params 1..6 -> 8 bytes accepted; cmd_in_params=0x04030201, cmd_in_sz=6, err_cnt=1.
REQ-031 Retire with rsp=0x5A, rsp_sz=3, and hold tipi_ready low for 3 cycles -> tipi_dat holds 0x11 while stalled; the output stream is {0x11, 0x01, 0x5A}; cmd_in_rsp_rdy returns high afterwards.
REQ-032 Commit and retire in the same cycle with 2 slots occupied -> occupancy stays 2, and both pointers advance by 1.
REQ-033 Pull reset low mid-parameter and mid-response -> all outputs return to their reset values; the next full packet is processed correctly.
